// File: rtl/neuron_param_loader_pkg.sv
// ---------------------------------------------------------------------------
// neuron_param_loader_pkg
// Shared types and sizing helpers for the neuron parameter loader.
//   state_e      : loader FSM states
//   out_width()  : neuron result width n+k+clog2(m)+2
//   frame_len()  : words per frame (bias + m weights + m activations)
// ---------------------------------------------------------------------------
package neuron_param_loader_pkg;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      FIRE    = 2'd1,
      WAIT    = 2'd2,
      RESULT  = 2'd3
   } state_e;

   function automatic int out_width(input int m, input int n, input int k);
      return n + k + $clog2(m) + 2;
   endfunction

   function automatic int frame_len(input int m);
      return 2 * m + 1;
   endfunction

endpackage

// File: rtl/neuron_param_loader.sv
// ---------------------------------------------------------------------------
// neuron_param_loader
// Streaming front end for the artificial neuron. Collects one bias, m weights
// and m activations from a valid/ready word stream into the neuron's parallel
// operand buses, strobes load_params for one cycle, waits LAT cycles and
// presents the neuron output on a valid/ready result port.
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          synchronous active-high reset
//   in_valid_i     stream word valid
//   in_ready_o     loader accepts a word this cycle
//   in_data_i      stream word (b+1 bits, signed)
//   load_params_o  one-cycle load strobe to the neuron
//   activation_o   m x k activations, element i at [i*k+:k]
//   weigth_o       m x n weights,     element i at [i*n+:n]
//   bias_o         signed bias (b+1 bits)
//   nrn_out_i      neuron result (already ReLU'd)
//   res_valid_o    result available
//   res_ready_i    consumer takes result
//   res_data_o     captured neuron result
// ---------------------------------------------------------------------------
module neuron_param_loader
   import neuron_param_loader_pkg::*;
#(
   parameter int m   = 4,
   parameter int n   = 4,
   parameter int k   = 4,
   parameter int b   = 10,
   parameter int LAT = 1
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                in_valid_i,
   output logic                                in_ready_o,
   input  logic [b:0]                          in_data_i,
   output logic                                load_params_o,
   output logic [m*k-1:0]                      activation_o,
   output logic [m*n-1:0]                      weigth_o,
   output logic [b:0]                          bias_o,
   input  logic [n+k+$clog2(m)+2-1:0]          nrn_out_i,
   output logic                                res_valid_o,
   input  logic                                res_ready_i,
   output logic [n+k+$clog2(m)+2-1:0]          res_data_o
);

   localparam int OUT_W = out_width(m, n, k);
   localparam int FRAME = frame_len(m);
   localparam int IDX_W = $clog2(FRAME);
   localparam int CNT_W = (LAT > 1) ? $clog2(LAT + 1) : 1;

   state_e             state_q;
   logic [IDX_W-1:0]   idx_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               in_ready_q;
   logic               load_params_q;
   logic [m*k-1:0]     activation_q;
   logic [m*n-1:0]     weigth_q;
   logic [b:0]         bias_q;
   logic               res_valid_q;
   logic [OUT_W-1:0]   res_data_q;

   logic               accept;
   assign accept = in_valid_i & in_ready_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= COLLECT;
         idx_q         <= '0;
         cnt_q         <= '0;
         in_ready_q    <= 1'b0;
         load_params_q <= 1'b0;
         activation_q  <= '0;
         weigth_q      <= '0;
         bias_q        <= '0;
         res_valid_q   <= 1'b0;
         res_data_q    <= '0;
      end else begin
         case (state_q)
            COLLECT: begin
               in_ready_q <= 1'b1;
               if (accept) begin
                  if (idx_q == '0)
                     bias_q <= in_data_i;
                  // Elements keep only their low bits; no saturation.
                  for (int i = 0; i < m; i++) begin
                     if (idx_q == IDX_W'(i + 1))
                        weigth_q[i*n +: n] <= in_data_i[n-1:0];
                     if (idx_q == IDX_W'(m + 1 + i))
                        activation_q[i*k +: k] <= in_data_i[k-1:0];
                  end
                  if (idx_q == IDX_W'(FRAME - 1)) begin
                     idx_q         <= '0;
                     in_ready_q    <= 1'b0;
                     load_params_q <= 1'b1;
                     state_q       <= FIRE;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            FIRE: begin
               load_params_q <= 1'b0;
               cnt_q         <= '0;
               state_q       <= WAIT;
            end
            // The neuron registers its result off the strobe, so its output
            // is valid from LAT cycles after FIRE; capture on the last of
            // the LAT WAIT cycles.
            WAIT: begin
               if (cnt_q == CNT_W'(LAT - 1)) begin
                  res_data_q  <= nrn_out_i;
                  res_valid_q <= 1'b1;
                  state_q     <= RESULT;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RESULT: begin
               // Handshake cycle accepts no word; in_ready rises after it.
               if (res_ready_i) begin
                  res_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= COLLECT;
               end
            end
            default: state_q <= COLLECT;
         endcase
      end
   end

   assign in_ready_o    = in_ready_q;
   assign load_params_o = load_params_q;
   assign activation_o  = activation_q;
   assign weigth_o      = weigth_q;
   assign bias_o        = bias_q;
   assign res_valid_o   = res_valid_q;
   assign res_data_o    = res_data_q;

endmodule

// File: tb/tb_neuron_param_loader.sv
module tb_neuron_param_loader;

   localparam int M = 4, N = 4, K = 4, B = 10, LAT = 1;
   localparam int OUT_W = N + K + $clog2(M) + 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [B:0]        in_data;
   logic              load_params;
   logic [M*K-1:0]    activation;
   logic [M*N-1:0]    weigth;
   logic [B:0]        bias;
   logic [OUT_W-1:0]  nrn_out;
   logic              res_valid;
   logic              res_ready;
   logic [OUT_W-1:0]  res_data;

   always #5 clk = ~clk;

   neuron_param_loader #(.m(M), .n(N), .k(K), .b(B), .LAT(LAT)) dut (
      .clk_i(clk), .rst_i(rst),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
      .load_params_o(load_params), .activation_o(activation),
      .weigth_o(weigth), .bias_o(bias), .nrn_out_i(nrn_out),
      .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data)
   );

   // Behavioural neuron: registers ReLU(bias + sum a*w) off load_params.
   function automatic int nrn_calc(input logic [B:0] bb, input logic [M*N-1:0] ww,
                                   input logic [M*K-1:0] aa);
      int s;
      s = int'($signed(bb));
      for (int i = 0; i < M; i++)
         s += int'($signed(ww[i*N +: N])) * int'($signed(aa[i*K +: K]));
      return (s < 0) ? 0 : s;
   endfunction

   always @(posedge clk) begin
      if (rst) nrn_out <= '0;
      else if (load_params) nrn_out <= OUT_W'(nrn_calc(bias, weigth, activation));
   end

   int n_tests = 0, n_fail = 0;
   int lp_cnt = 0, acc_cnt = 0;
   int last_lat;
   int fb;
   int fw[M];
   int fa[M];

   always @(posedge clk) begin
      if (load_params) lp_cnt++;
      if (in_valid && in_ready) acc_cnt++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int sx4(input int v);
      int t;
      t = v & 15;
      return (t >= 8) ? t - 16 : t;
   endfunction

   function automatic int gold();
      int s;
      s = fb;
      for (int i = 0; i < M; i++) s += sx4(fw[i]) * sx4(fa[i]);
      return (s < 0) ? 0 : s;
   endfunction

   task automatic send_word(input int d, input int gap);
      int t;
      repeat (gap) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data  = (B+1)'(d);
      t = 0;
      while (!in_ready && t < 200) begin @(posedge clk); #1; t++; end
      if (t >= 200) chk("in_ready_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input int gapmax, input int nwords);
      for (int i = 0; i < nwords; i++) begin
         int d;
         if (i == 0) d = fb;
         else if (i <= M) d = fw[i-1];
         else d = fa[i-M-1];
         send_word(d, (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
      end
   endtask

   task automatic get_result(input string tag, input int exp, input int hold);
      int t;
      t = 0;
      if (hold > 0) res_ready = 1'b0;
      while (!res_valid && t < 50) begin @(posedge clk); #1; t++; end
      if (t >= 50) chk({tag, "_timeout"}, 0, 1);
      last_lat = t;
      chk(tag, 64'(res_data), 64'(exp));
      repeat (hold) begin @(posedge clk); #1; end
      res_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic set_frame(input int bb, input int w0, input int w1, input int w2, input int w3,
                            input int a0, input int a1, input int a2, input int a3);
      fb = bb;
      fw[0] = w0; fw[1] = w1; fw[2] = w2; fw[3] = w3;
      fa[0] = a0; fa[1] = a1; fa[2] = a2; fa[3] = a3;
   endtask

   initial begin
      int lp0, acc0;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; res_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(in_ready), 0);
      chk("rst_res_valid", 64'(res_valid), 0);
      chk("rst_load_params", 64'(load_params), 0);
      chk("rst_bias", 64'(bias), 0);
      rst = 1'b0;

      // Directed frames
      set_frame(5, 1, 2, 3, 4, 1, 1, 1, 1);
      lp0 = lp_cnt;
      send_frame(0, 2*M+1);
      get_result("basic_sum", 15, 0);
      chk("basic_latency", 64'(last_lat), 64'(LAT + 1));
      chk("basic_lp_pulses", 64'(lp_cnt - lp0), 1);
      chk("basic_weigth_bus", 64'(weigth), 64'(16'h4321));
      chk("basic_act_bus", 64'(activation), 64'(16'h1111));

      set_frame(-100, 7, 7, 7, 7, 1, 1, 1, 1);
      send_frame(0, 2*M+1);
      get_result("relu_zero", 0, 0);

      set_frame(-8, -8, -8, -8, -8, -8, -8, -8, -8);
      send_frame(1, 2*M+1);
      get_result("neg_corner", 248, 0);

      // Result stall: result held, input blocked
      set_frame(20, 1, -1, 2, 3, 2, 3, -1, 1);
      res_ready = 1'b0;
      send_frame(2, 2*M+1);
      begin
         int t;
         t = 0;
         while (!res_valid && t < 50) begin @(posedge clk); #1; t++; end
         if (t >= 50) chk("stall_timeout", 0, 1);
      end
      acc0 = acc_cnt;
      in_valid = 1'b1; in_data = 11'd9;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (c == 0 || c == 9) begin
            chk("stall_res_valid", 64'(res_valid), 1);
            chk("stall_res_data", 64'(res_data), 20);
            chk("stall_in_ready", 64'(in_ready), 0);
         end
      end
      chk("stall_no_consume", 64'(acc_cnt - acc0), 0);
      in_valid = 1'b0;
      res_ready = 1'b1;
      @(posedge clk); #1;
      chk("stall_released", 64'(res_valid), 0);
      chk("stall_in_ready_after", 64'(in_ready), 1);
      set_frame(-3, 3, 3, 3, 3, 2, -2, 1, 0);
      send_frame(1, 2*M+1);
      get_result("after_stall", 0, 0);
      set_frame(100, 5, -3, 0, 2, -4, 6, 7, 3);
      send_frame(0, 2*M+1);
      get_result("after_stall2", 68, 0);

      // Reset after 5 words of a frame
      set_frame(300, 7, 7, 7, 7, 7, 7, 7, 7);
      send_frame(0, 5);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_bias", 64'(bias), 0);
      chk("mid_rst_weigth", 64'(weigth), 0);
      chk("mid_rst_act", 64'(activation), 0);
      chk("mid_rst_in_ready", 64'(in_ready), 0);
      rst = 1'b0;
      set_frame(3, 1, 1, 1, 1, 2, 2, 2, 2);
      send_frame(0, 2*M+1);
      get_result("post_rst", 11, 0);

      // Random frames
      lp0 = lp_cnt;
      for (int f = 0; f < 1500; f++) begin
         fb = int'($urandom_range(0, 2047)) - 1024;
         for (int i = 0; i < M; i++) begin
            fw[i] = int'($urandom_range(0, 2047)) - 1024;
            fa[i] = int'($urandom_range(0, 2047)) - 1024;
         end
         send_frame(2, 2*M+1);
         get_result("rand_frame", gold(), int'($urandom_range(0, 2)));
      end
      chk("rand_lp_pulses", 64'(lp_cnt - lp0), 1500);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
